// File: rtl/counter_pkg.sv
// Shared encodings for the counter sequencer: command opcodes, FSM states
// and run modes.
package counter_pkg;

    // Command opcodes presented on cmd_op
    typedef enum logic [1:0] {
        OP_NOP            = 2'b00,
        OP_START_ONESHOT  = 2'b01,
        OP_START_PERIODIC = 2'b10,
        OP_STOP           = 2'b11
    } cmd_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Run mode latched on START acceptance
    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    // Default sizes used by the sequencer and its bench
    localparam int DEFAULT_SIZE         = 5;
    localparam int DEFAULT_PERIOD_WIDTH = 8;

endpackage : counter_pkg

// File: rtl/counter_sequencer.sv
// Sequences an external free-running counter through its synchronous reset.
// Accepts one-shot / periodic / stop commands over valid/ready, compares the
// counter value with a latched limit and emits registered tick/done pulses
// plus a saturating count of periodic completions.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int Size        = DEFAULT_SIZE,
    parameter int PeriodWidth = DEFAULT_PERIOD_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [Size-1:0]        cmd_limit,
    input  logic [Size-1:0]        count,
    output logic                   counter_reset,
    output logic                   tick,
    output logic                   done,
    output logic                   busy,
    output logic [PeriodWidth-1:0] periods
);

    localparam logic [PeriodWidth-1:0] PERIODS_ONE = {{(PeriodWidth-1){1'b0}}, 1'b1};

    state_e                 state_reg, state_next;
    logic [Size-1:0]        limit_reg, limit_next;
    mode_e                  mode_reg, mode_next;
    logic                   tick_reg, tick_next;
    logic                   done_reg, done_next;
    logic [PeriodWidth-1:0] periods_reg, periods_next;

    logic                   accept;
    logic                   start_acc;
    logic                   stop_acc;
    logic                   hit;
    logic [Size-1:0]        bit_match;

    // Per-bit equality between the counter and the latched limit
    generate
        for (genvar gi = 0; gi < Size; gi++) begin : g_match
            assign bit_match[gi] = (count[gi] == limit_reg[gi]);
        end
    endgenerate

    // Terminal count is only meaningful while running; strict equality so an
    // overshooting counter wraps around and hits on its next pass.
    assign hit = (state_reg == ST_RUN) && (&bit_match);

    // Handshake decode. NOP is accepted but has no effect at all, so only
    // START and STOP are treated as commands.
    assign accept    = cmd_valid && cmd_ready;
    assign start_acc = accept && ((cmd_op == OP_START_ONESHOT) || (cmd_op == OP_START_PERIODIC));
    assign stop_acc  = accept && (cmd_op == OP_STOP);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; an accepted command takes priority over a hit
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_acc) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_acc) begin
                    state_next = ST_IDLE;
                end else if (start_acc) begin
                    state_next = ST_RUN;
                end else if (hit && (mode_reg == MODE_ONESHOT)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; reset holds the counter and blocks commands
    always_comb begin
        cmd_ready     = !reset && (state_reg != ST_DONE);
        busy          = !reset && (state_reg == ST_RUN);
        counter_reset = reset || (state_reg != ST_RUN) || hit || start_acc || stop_acc;
    end

    // Next values of the latched command and the registered event outputs
    always_comb begin
        limit_next   = limit_reg;
        mode_next    = mode_reg;
        tick_next    = hit;
        done_next    = hit && (mode_reg == MODE_ONESHOT) && !start_acc && !stop_acc;
        periods_next = periods_reg;

        if (start_acc) begin
            limit_next = cmd_limit;
            mode_next  = (cmd_op == OP_START_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;
        end

        // A START clears the completion count even if a hit lands on the same edge
        if (start_acc) begin
            periods_next = '0;
        end else if (hit && (mode_reg == MODE_PERIODIC) && (periods_reg != '1)) begin
            periods_next = periods_reg + PERIODS_ONE;
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            limit_reg   <= '0;
            mode_reg    <= MODE_ONESHOT;
            tick_reg    <= 1'b0;
            done_reg    <= 1'b0;
            periods_reg <= '0;
        end else begin
            limit_reg   <= limit_next;
            mode_reg    <= mode_next;
            tick_reg    <= tick_next;
            done_reg    <= done_next;
            periods_reg <= periods_next;
        end
    end

    assign tick    = tick_reg;
    assign done    = done_reg;
    assign periods = periods_reg;

endmodule : counter_sequencer

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a peer counter, a cycle-level behavioural
// model, directed scenarios with literal expectations and a random phase.
module tb_counter_sequencer;
    import counter_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [4:0] cmd_limit = 5'd0;
    logic [4:0] count;
    logic       cmd_ready, counter_reset, tick, done, busy;
    logic [7:0] periods;

    counter_sequencer #(.Size(5), .PeriodWidth(8)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_limit(cmd_limit), .count(count),
        .counter_reset(counter_reset), .tick(tick), .done(done), .busy(busy),
        .periods(periods)
    );

    always #5 clock = ~clock;

    // Peer counter: cleared by counter_reset, otherwise wraps at 32
    always @(posedge clock) count <= counter_reset ? 5'd0 : count + 5'd1;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Behavioural model: values valid for the current cycle
    bit m_run = 0, m_donecyc = 0, m_oneshot = 1, m_tick = 0, m_done = 0;
    int m_limit = 0, m_phase = 0, m_periods = 0;

    // Per-cycle recordings for directed scenarios (index = cycles after acceptance)
    int tick_at[0:400], done_at[0:400], count_at[0:400], busy_at[0:400], periods_at[0:400];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !reset && !m_donecyc;
    endfunction
    function automatic bit m_start();
        return cmd_valid && m_ready() && (cmd_op == OP_START_ONESHOT || cmd_op == OP_START_PERIODIC);
    endfunction
    function automatic bit m_stop();
        return cmd_valid && m_ready() && (cmd_op == OP_STOP);
    endfunction
    function automatic bit m_hit();
        return m_run && (m_phase == m_limit);
    endfunction

    // Advance the model across one clock edge using the inputs just applied
    task automatic model_update();
        bit h, s, p, nd;
        h = m_hit(); s = m_start(); p = m_stop(); nd = 0;
        if (reset) begin
            m_run = 0; m_donecyc = 0; m_oneshot = 1; m_limit = 0; m_phase = 0;
            m_tick = 0; m_done = 0; m_periods = 0;
        end else begin
            m_tick = h;
            m_done = h && m_oneshot && !s && !p;
            if (s) m_periods = 0;
            else if (h && !m_oneshot) m_periods = (m_periods >= 255) ? 255 : m_periods + 1;
            if (s) begin
                m_run = 1; m_phase = 0; m_limit = int'(cmd_limit);
                m_oneshot = (cmd_op == OP_START_ONESHOT);
            end else if (p) begin
                m_run = 0;
            end else if (h && m_oneshot) begin
                m_run = 0; nd = 1;
            end else if (m_run) begin
                m_phase = h ? 0 : (m_phase + 1) % 32;
            end
            m_donecyc = nd;
        end
    endtask

    // One cycle: apply inputs, take the edge, update the model
    task automatic step(input bit v, input logic [1:0] op, input int lim, input bit r);
        cmd_valid = v; cmd_op = op; cmd_limit = lim[4:0]; reset = r;
        @(posedge clock);
        model_update();
        #1;
    endtask

    // Record outputs for cycles 1..n with no commands presented
    task automatic run_rec(input int n);
        for (int c = 1; c <= n; c++) begin
            tick_at[c] = int'(tick); done_at[c] = int'(done); count_at[c] = int'(count);
            busy_at[c] = int'(busy); periods_at[c] = int'(periods);
            step(0, OP_NOP, 0, 0);
        end
    endtask

    function automatic int sum_of(input int which, input int lo, input int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) begin
            case (which)
                0: s += tick_at[c];
                1: s += done_at[c];
                2: s += count_at[c];
                default: s += busy_at[c];
            endcase
        end
        return s;
    endfunction

    function automatic int first_of(input int which, input int n);
        for (int c = 1; c <= n; c++) begin
            if ((which == 0 && tick_at[c] != 0) || (which == 1 && done_at[c] != 0)) return c;
        end
        return -1;
    endfunction

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clock) begin
        if (chk_en) begin
            chk("count", count, m_run ? m_phase : 0);
            chk("busy", busy, int'(m_run && !reset));
            chk("cmd_ready", cmd_ready, int'(m_ready()));
            chk("counter_reset", counter_reset, int'(reset || !m_run || m_hit() || m_start() || m_stop()));
            chk("tick", tick, int'(m_tick));
            chk("done", done, int'(m_done));
            chk("periods", periods, m_periods);
        end
    end

    initial begin
        step(0, OP_NOP, 0, 1);
        step(0, OP_NOP, 0, 1);
        chk_en = 1;
        chk("rst_tick", tick, 0); chk("rst_done", done, 0); chk("rst_periods", periods, 0);
        chk("rst_ready", cmd_ready, 0); chk("rst_creset", counter_reset, 1);
        step(0, OP_NOP, 0, 0);
        chk("idle_ready", cmd_ready, 1); chk("idle_count", count, 0);

        // One-shot limit 3
        step(1, OP_START_ONESHOT, 3, 0);
        run_rec(8);
        chk("os3_done_cycle", first_of(1, 8), 5);
        chk("os3_done_n", sum_of(1, 1, 8), 1);
        chk("os3_tick5", tick_at[5], 1);
        chk("os3_busy_n", sum_of(3, 1, 8), 4);
        chk("os3_count4", count_at[4], 3);
        chk("os3_count6", count_at[6], 0);

        // Periodic limit 4, then STOP on a non-hit cycle
        step(1, OP_START_PERIODIC, 4, 0);
        run_rec(17);
        chk("per4_ticks", sum_of(0, 1, 17), 3);
        chk("per4_t6", tick_at[6], 1); chk("per4_t11", tick_at[11], 1); chk("per4_t16", tick_at[16], 1);
        chk("per4_p6", periods_at[6], 1); chk("per4_p11", periods_at[11], 2); chk("per4_p16", periods_at[16], 3);
        chk("per4_stop_cnt", count, 2);
        step(1, OP_STOP, 0, 0);
        run_rec(4);
        chk("stop_busy", sum_of(3, 1, 4), 0);
        chk("stop_done", sum_of(1, 1, 4), 0);

        // START presented on a hit cycle
        step(1, OP_START_PERIODIC, 4, 0);
        run_rec(4);
        chk("hitstart_cnt", count, 4);
        step(1, OP_START_PERIODIC, 2, 0);
        run_rec(9);
        chk("hs_t1", tick_at[1], 1); chk("hs_p1", periods_at[1], 0); chk("hs_c1", count_at[1], 0);
        chk("hs_t4", tick_at[4], 1); chk("hs_t7", tick_at[7], 1); chk("hs_p7", periods_at[7], 2);
        chk("hs_ticks", sum_of(0, 1, 9), 3);
        step(1, OP_STOP, 0, 0);
        step(0, OP_NOP, 0, 0);

        // START presented during DONE
        step(1, OP_START_ONESHOT, 1, 0);
        step(0, OP_NOP, 0, 0);
        step(0, OP_NOP, 0, 0);
        chk("dn_ready", cmd_ready, 0); chk("dn_done", done, 1);
        step(1, OP_START_ONESHOT, 2, 0);
        chk("dn_notacc_busy", busy, 0); chk("dn_idle_ready", cmd_ready, 1);
        step(1, OP_START_ONESHOT, 2, 0);
        chk("dn_acc_busy", busy, 1);
        run_rec(6);
        chk("dn_os2_done", first_of(1, 6), 4);

        // Periodic limit 0 for 300 cycles
        step(1, OP_START_PERIODIC, 0, 0);
        run_rec(300);
        chk("z_t1", tick_at[1], 0);
        chk("z_ticks", sum_of(0, 2, 300), 299);
        chk("z_count", sum_of(2, 1, 300), 0);
        chk("z_p255", periods_at[255], 254);
        chk("z_p256", periods_at[256], 255);
        chk("z_p300", periods_at[300], 255);
        step(1, OP_STOP, 0, 0);
        step(0, OP_NOP, 0, 0);

        // One-shot limit 0 and 31
        step(1, OP_START_ONESHOT, 0, 0);
        run_rec(4);
        chk("os0_done", first_of(1, 4), 2);
        step(1, OP_START_ONESHOT, 31, 0);
        run_rec(36);
        chk("os31_done", first_of(1, 36), 33);
        chk("os31_c32", count_at[32], 31);
        chk("os31_c1", count_at[1], 0);

        // Reset in cycle 2 of a one-shot with limit 7
        step(1, OP_START_ONESHOT, 7, 0);
        run_rec(1);
        step(0, OP_NOP, 0, 1);
        chk("mr_tick", tick, 0); chk("mr_done", done, 0); chk("mr_periods", periods, 0);
        chk("mr_busy", busy, 0); chk("mr_creset", counter_reset, 1); chk("mr_count", count, 0);
        step(0, OP_NOP, 0, 0);
        chk("mr_ready", cmd_ready, 1);
        run_rec(12);
        chk("mr_nodone", sum_of(1, 1, 12), 0);

        // Random commands against the model
        for (int i = 0; i < 3000; i++) begin
            bit v, r;
            logic [1:0] op;
            int lim;
            r = ($urandom_range(0, 149) == 0);
            lim = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            if (m_run) begin
                v = ($urandom_range(0, 7) == 0);
                op = 2'($urandom_range(1, 3));
            end else begin
                v = ($urandom_range(0, 2) == 0);
                op = 2'($urandom_range(0, 3));
            end
            step(v, op, lim, r);
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_counter_sequencer
